// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: op encodings (Funct3),
// the M-type Funct7 tag and the sequencer FSM states.
package riscv_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_op_e;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration step: shift-add multiply (LSB first) or restoring
// shift-subtract divide. The accumulator is {hi, lo}.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     opnd_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, opnd_i});
      // When ge holds the true difference is below 2^WIDTH, so the low bits suffice.
      diff   = rem_sh[WIDTH-1:0] - opnd_i;
      if (is_div_i) begin
         if (ge) begin
            acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: WIDTH+1 cycles per op (1 for divide
// special cases), stalls the pipeline while busy, flush aborts without a done pulse.
module muldiv_sequencer
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] Result
);

   localparam int CNT_W = $clog2(WIDTH);

   muldiv_state_e      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               div_zero, div_ovf;
   logic [2*WIDTH-1:0] acc_nxt, prod;
   logic [WIDTH-1:0]   quo, rem, fix_res;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .is_div_i (op_q[2]),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_nxt)
   );

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (muldiv_op_e'(Funct3))
         MUL, MULH, DIV, REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         MULHSU:  a_sgn = 1'b1;
         default: ;
      endcase
      a_neg    = a_sgn & SrcA[WIDTH-1];
      b_neg    = b_sgn & SrcB[WIDTH-1];
      a_mag    = a_neg ? -SrcA : SrcA;
      b_mag    = b_neg ? -SrcB : SrcB;
      div_zero = (SrcB == '0);
      div_ovf  = !Funct3[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
   end

   // Sign fixup and result selection, applied to the final iteration's accumulator.
   always_comb begin
      prod = neg_q  ? -acc_nxt : acc_nxt;
      quo  = neg_q  ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
      rem  = rneg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
      if (op_q[2]) begin
         fix_res = op_q[1] ? rem : quo;
      end else begin
         fix_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_d   = Funct3;
                  neg_d  = a_neg ^ b_neg;
                  rneg_d = a_neg;
                  cnt_d  = CNT_W'(WIDTH - 1);
                  opnd_d = Funct3[2] ? b_mag : a_mag;
                  acc_d  = {{WIDTH{1'b0}}, (Funct3[2] ? a_mag : b_mag)};
                  if (Funct3[2] && div_zero) begin
                     result_d = Funct3[1] ? SrcA : '1;
                     state_d  = FIN;
                  end else if (Funct3[2] && div_ovf) begin
                     result_d = Funct3[1] ? '0 : SrcA;
                     state_d  = FIN;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               acc_d = acc_nxt;
               if (cnt_q == '0) begin
                  result_d = fix_res;
                  state_d  = FIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign stall  = ((state_q == IDLE) && start) || (state_q == CALC);
   assign done   = (state_q == FIN) && !flush;
   assign Result = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting in the execute stage beside the single-cycle ALU.
- Accepts one operation when the decoder flags an M-type R instruction (Funct7 = 0000001), iterates one bit per cycle, and stalls the pipeline until the result is ready.
- Drives a registered result and a one-cycle done pulse to the EX/MEM mux.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch operation; sampled only in IDLE
- Funct3  input  3  M-extension op select (instruction bits 14:12)
- SrcA  input  WIDTH  rs1 operand (multiplicand/dividend)
- SrcB  input  WIDTH  rs2 operand (multiplier/divisor)
- flush  input  1  abort in-flight operation (branch taken/exception)
- stall  output  1  hold IF/ID/EX pipeline registers
- done  output  1  one-cycle result-valid pulse
- Result  output  WIDTH  operation result, valid while done=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, done=0, Result=0, counter=0, all internal registers 0. stall is combinational and therefore 0 under reset.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 latches Funct3, the operand magnitudes and the result sign.
  - For signed operands (per Funct3), the absolute value is taken. For MULHSU only SrcA is signed.
  - Next state is CALC with counter=WIDTH-1.
  - Special divide cases (Funct3[2]=1) skip CALC and go straight to FIN:
    - divisor==0: quotient = all ones; remainder = SrcA.
    - signed overflow (DIV/REM with SrcA=1 followed by WIDTH-1 zeros and SrcB=all ones): quotient = SrcA; remainder = 0.
- CALC, one iteration per cycle:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - When counter==0, go to FIN; otherwise decrement the counter.
- FIN:
  - Sign fixup: negate the product if the operand signs differ. Quotient takes sign(A) xor sign(B); remainder takes sign(A).
  - Result selection: MUL = low WIDTH bits; MULH/MULHSU/MULHU = high WIDTH bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Result is registered, done=1 for exactly one cycle, then the state returns to IDLE.
- Latency:
  - Normal operation: done is asserted WIDTH+1 cycles after the start edge (33 for WIDTH=32).
  - Special divide cases: done is asserted 1 cycle after start.
- stall = (state==IDLE && start) || state==CALC. It is low in FIN so the pipeline advances and captures Result alongside done.
- start asserted outside IDLE is ignored. Back-to-back: start asserted in the cycle after FIN is accepted.
- flush has priority over everything:
  - Any state goes to IDLE on the next edge, and done is never asserted for the aborted operation.
  - In FIN, flush suppresses done in that cycle (done is gated by !flush).
  - flush together with start in IDLE means start is ignored.
- Result holds its last value between operations; consumers qualify it with done.
- Arithmetic rules:
  - All internal arithmetic is unsigned on WIDTH+1 bits (divide) or 2*WIDTH bits (multiply).
  - Negation is two's complement, truncated to the destination width.
  - No X propagation on Funct3 values with undefined upper bits.

Decomposition:
- Shared package riscv_pkg holds:
  - muldiv_op_e enum with MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011, DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111.
  - FUNCT7_MULDIV = 7'b0000001.
  - muldiv_state_e {IDLE, CALC, FIN}.
- One natural sub-module, muldiv_iter: the combinational single-step shift-add / shift-subtract unit, instantiated once. The FSM, counter and sign logic stay in muldiv_sequencer.

Test Plan:
- MUL with SrcA=7, SrcB=0xFFFFFFFD -> stall high for 33 cycles; done at cycle 33; Result=0xFFFFFFEB.
- MULH with 0x80000000 x 0x80000000 -> Result=0x40000000. MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> Result=0xFFFFFFFE.
- DIV with 0xFFFFFFF9 / 2 -> Result=0xFFFFFFFD. REM with the same operands -> Result=0xFFFFFFFF. DIVU with 100 / 7 -> Result=14.
- DIVU 5/0 -> done 1 cycle after start with Result=0xFFFFFFFF. REMU 5/0 -> Result=5. DIV 0x80000000 / 0xFFFFFFFF -> Result=0x80000000. REM with the same operands -> Result=0.
- Abort and restart:
  - Start MUL 3x4, assert flush at cycle 10 -> state is IDLE next cycle; stall=0; no done pulse.
  - A new MUL 5x6 started immediately after -> Result=30 at cycle 33.
- Reset and ignored start:
  - reset asserted mid-CALC (asynchronous, between edges) -> stall, done and Result are 0 immediately.
  - start pulsed during CALC -> ignored; only one done pulse is produced.
